// File: rtl/dpe_accum.sv
// Pipelined LANES-wide dot-product engine with a running accumulator and a FWFT result FIFO.
// Path: input reg -> lane products -> registered adder tree -> post-tree reg -> accumulate + FIFO write.
module dpe_accum #(
  parameter int LANES      = 64,
  parameter int IPREC      = 8,
  parameter int OPREC      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SAT        = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [LANES*IPREC-1:0] i_dataa,
  input  logic [LANES*IPREC-1:0] i_datab,
  input  logic                   i_signed,
  input  logic                   i_first,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [OPREC-1:0]       o_result
);
  localparam int LOG  = $clog2(LANES);
  localparam int PW   = 2*IPREC + 2;
  localparam int NEED = 2*IPREC + LOG + 1;
  // The tree is kept wide enough for the full dot product even when OPREC is narrower,
  // so saturation sees the true beat sum rather than an already-wrapped one.
  localparam int TW   = (OPREC > NEED) ? OPREC : NEED;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1) + 1;

  typedef struct packed {
    logic vld;
    logic sgn;
    logic first;
    logic last;
  } ctl_t;

  logic                    accept;
  ctl_t                    in_ctl_q, mul_ctl_q, pst_ctl_q;
  ctl_t                    tree_ctl_q [LOG];
  logic [LANES*IPREC-1:0]  in_a_q, in_b_q;
  logic signed [TW-1:0]    node [2*LANES-1];
  logic signed [TW-1:0]    pst_sum_q;
  logic signed [OPREC-1:0] acc_q, acc_base;
  logic signed [TW:0]      acc_wide, max_w, min_w;
  logic [OPREC-1:0]        acc_d;
  logic                    fifo_wr, fifo_rd;
  logic [OPREC-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q, infl_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  // Credits cover both stored results and i_last beats still in the pipe, so no write can overflow.
  assign accept  = i_valid & i_ready;
  assign i_ready = (cnt_q + infl_q) < CW'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ctl_q  <= '0;
      in_a_q    <= '0;
      in_b_q    <= '0;
      mul_ctl_q <= '0;
      pst_ctl_q <= '0;
      pst_sum_q <= '0;
      for (int k = 0; k < LOG; k++) tree_ctl_q[k] <= '0;
    end else begin
      in_ctl_q <= accept ? {1'b1, i_signed, i_first, i_last} : '0;
      if (accept) begin
        in_a_q <= i_dataa;
        in_b_q <= i_datab;
      end
      mul_ctl_q     <= in_ctl_q;
      tree_ctl_q[0] <= mul_ctl_q;
      for (int k = 1; k < LOG; k++) tree_ctl_q[k] <= tree_ctl_q[k-1];
      pst_ctl_q <= tree_ctl_q[LOG-1];
      pst_sum_q <= node[0];
    end
  end

  // Leaves of the heap-ordered tree: node[LANES-1+gi] holds lane gi's product.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [IPREC:0]  ea, eb;
    logic signed [PW-1:0]   prod;
    logic signed [TW-1:0]   prod_q;
    assign ea   = {in_ctl_q.sgn & in_a_q[(gi+1)*IPREC-1], in_a_q[gi*IPREC +: IPREC]};
    assign eb   = {in_ctl_q.sgn & in_b_q[(gi+1)*IPREC-1], in_b_q[gi*IPREC +: IPREC]};
    assign prod = PW'(ea) * PW'(eb);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prod_q <= '0;
      else        prod_q <= TW'(prod);
    end
    assign node[LANES-1+gi] = prod_q;
  end

  for (genvar gi = 0; gi < LANES-1; gi++) begin : g_node
    logic signed [TW-1:0] sum_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_q <= '0;
      else        sum_q <= node[2*gi+1] + node[2*gi+2];
    end
    assign node[gi] = sum_q;
  end

  assign max_w    = {{(TW-OPREC+2){1'b0}}, {(OPREC-1){1'b1}}};
  assign min_w    = ~max_w;
  assign acc_base = pst_ctl_q.first ? '0 : acc_q;

  always_comb begin
    acc_wide = (TW+1)'(pst_sum_q) + (TW+1)'(acc_base);
    acc_d    = acc_wide[OPREC-1:0];
    if (SAT != 0 && pst_ctl_q.sgn) begin
      if (acc_wide > max_w)      acc_d = max_w[OPREC-1:0];
      else if (acc_wide < min_w) acc_d = min_w[OPREC-1:0];
    end
  end

  assign fifo_wr  = pst_ctl_q.vld & pst_ctl_q.last;
  assign fifo_rd  = o_valid & o_ready;
  assign o_valid  = (cnt_q != '0);
  assign o_result = o_valid ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      infl_q   <= '0;
    end else begin
      if (pst_ctl_q.vld) acc_q <= pst_ctl_q.last ? '0 : acc_d;
      if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q  <= cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
      infl_q <= infl_q + CW'(accept & i_last) - CW'(fifo_wr);
    end
  end

endmodule

// File: tb/tb_dpe_accum.sv
// Bench for dpe_accum: directed scenarios plus randomized beats against a plain-arithmetic
// dot-product/accumulate model; two narrow instances exercise saturation vs wrap.
module tb_dpe_accum;
  localparam int LANES = 64;
  localparam int IPREC = 8;
  localparam int W     = LANES*IPREC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] da, db;
  logic         sgn, first, last, v_main, v_sat, rdy_main, rdy_sat;
  logic         hold_rdy, rnd_rdy;
  logic         i_ready_m, o_valid_m;
  logic [31:0]  o_result_m;
  logic         i_ready_s1, o_valid_s1, i_ready_s0, o_valid_s0;
  logic [15:0]  o_result_s1, o_result_s0;

  int           n_pass = 0;
  int           n_checks = 0;
  int           accepts = 0;
  logic [31:0]  exp_q[$];
  longint       macc;

  dpe_accum #(.LANES(64), .IPREC(8), .OPREC(32), .FIFO_DEPTH(4), .SAT(0)) u_main (
    .clk(clk), .rst_n(rst_n), .i_valid(v_main), .i_ready(i_ready_m),
    .i_dataa(da), .i_datab(db), .i_signed(sgn), .i_first(first), .i_last(last),
    .o_valid(o_valid_m), .o_ready(rdy_main), .o_result(o_result_m));

  dpe_accum #(.LANES(64), .IPREC(8), .OPREC(16), .FIFO_DEPTH(4), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_valid(v_sat), .i_ready(i_ready_s1),
    .i_dataa(da), .i_datab(db), .i_signed(sgn), .i_first(first), .i_last(last),
    .o_valid(o_valid_s1), .o_ready(rdy_sat), .o_result(o_result_s1));

  dpe_accum #(.LANES(64), .IPREC(8), .OPREC(16), .FIFO_DEPTH(4), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .i_valid(v_sat), .i_ready(i_ready_s0),
    .i_dataa(da), .i_datab(db), .i_signed(sgn), .i_first(first), .i_last(last),
    .o_valid(o_valid_s0), .o_ready(rdy_sat), .o_result(o_result_s0));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
  endtask

  // Dot product of the currently driven beat, with per-beat signedness.
  function automatic longint lane_sum();
    longint s = 0;
    for (int j = 0; j < LANES; j++) begin
      int av, bv;
      av = sgn ? int'($signed(da[j*IPREC +: IPREC])) : int'(da[j*IPREC +: IPREC]);
      bv = sgn ? int'($signed(db[j*IPREC +: IPREC])) : int'(db[j*IPREC +: IPREC]);
      s += longint'(av * bv);
    end
    return s;
  endfunction

  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (!rst_n) begin
      exp_q.delete();
      macc = 0;
    end else begin
      if (o_valid_m && rdy_main) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 64'(o_valid_m), 64'd0);
        end else begin
          e = exp_q.pop_front();
          $display("pop result=%h model=%h", o_result_m, e);
          check("result", 64'(o_result_m), 64'(e));
        end
      end
      if (v_main && i_ready_m) begin
        accepts++;
        macc = ((first ? 64'sd0 : macc) + lane_sum()) & 64'hFFFF_FFFF;
        if (last) begin
          exp_q.push_back(macc[31:0]);
          macc = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rdy_main = hold_rdy ? 1'b0 : (rnd_rdy ? ($urandom_range(3) != 0) : 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b);
    for (int j = 0; j < LANES; j++) begin
      da[j*IPREC +: IPREC] = a;
      db[j*IPREC +: IPREC] = b;
    end
  endtask

  task automatic rand_fill();
    for (int j = 0; j < W/32; j++) begin
      da[j*32 +: 32] = $urandom;
      db[j*32 +: 32] = $urandom;
    end
  endtask

  task automatic send(input bit to_sat, input bit s, input bit f, input bit l);
    int n = 0;
    sgn = s; first = f; last = l;
    if (to_sat) v_sat = 1'b1;
    else        v_main = 1'b1;
    @(negedge clk);
    while (!(to_sat ? i_ready_s1 : i_ready_m) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_wait", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    v_main = 1'b0;
    v_sat  = 1'b0;
  endtask

  task automatic wait_valid(input bit sat_dut);
    int n = 0;
    while (!(sat_dut ? o_valid_s1 : o_valid_m) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("valid_wait", 64'(n), 64'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] v);
    wait_valid(1'b0);
    check(tag, 64'(o_result_m), 64'(v));
    hold_rdy = 1'b0;
    wait_drain();
    hold_rdy = 1'b1;
  endtask

  task automatic pop_sat();
    rdy_sat = 1'b1;
    tick();
    rdy_sat = 1'b0;
    check("sat_popped", 64'(o_valid_s1), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b1; da = '0; db = '0; sgn = 0; first = 0; last = 0;
    v_main = 0; v_sat = 0; rdy_main = 0; rdy_sat = 0; hold_rdy = 1; rnd_rdy = 0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_iready", 64'(i_ready_m), 64'd1);
    check("rst_ovalid", 64'(o_valid_m), 64'd0);
    check("rst_oresult", 64'(o_result_m), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Latency and basic unsigned result
    fill(8'd1, 8'd1);
    send(0, 0, 1, 1);
    n = 1;
    while (!o_valid_m && n < 40) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'd10);
    check("ones", 64'(o_result_m), 64'd64);
    hold_rdy = 1'b0;
    wait_drain();
    hold_rdy = 1'b1;

    // Signed extremes
    fill(8'h80, 8'h80);
    send(0, 1, 1, 1);
    expect_head("neg_sq", 32'd1048576);
    fill(8'hFF, 8'h01);
    send(0, 1, 1, 1);
    expect_head("neg_one", 32'hFFFF_FFC0);

    // Multi-beat accumulation, then a beat lacking i_first
    fill(8'd2, 8'd3);
    send(0, 0, 1, 0);
    send(0, 0, 0, 0);
    send(0, 0, 0, 1);
    expect_head("three_beat", 32'd1152);
    fill(8'd1, 8'd1);
    send(0, 0, 0, 1);
    expect_head("no_first", 32'd64);

    // Backpressure: FIFO full of credits after 4 single-beat results
    accepts = 0;
    sgn = $urandom; first = 1; last = 1;
    v_main = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_fill();
      tick();
    end
    v_main = 1'b0;
    check("bp_accepts", 64'(accepts), 64'd4);
    check("bp_iready", 64'(i_ready_m), 64'd0);
    check("bp_ovalid", 64'(o_valid_m), 64'd1);
    hold_rdy = 1'b0;
    wait_drain();
    repeat (3) tick();
    check("bp_iready_back", 64'(i_ready_m), 64'd1);

    // Randomized beats with random downstream stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(3) == 0) tick();
      rand_fill();
      send(0, 1'($urandom), ($urandom_range(3) == 0), ($urandom_range(2) == 0));
    end
    rand_fill();
    send(0, 1'($urandom), 0, 1);
    wait_drain();
    rnd_rdy = 1'b0;
    hold_rdy = 1'b1;
    tick();

    // Reset mid-operation with two stored results and a partial accumulation in flight
    fill(8'd3, 8'd5);
    send(0, 0, 1, 1);
    fill(8'd7, 8'd7);
    send(0, 0, 1, 1);
    send(0, 0, 1, 0);
    send(0, 0, 0, 0);
    repeat (8) tick();
    check("pre_rst_valid", 64'(o_valid_m), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ovalid", 64'(o_valid_m), 64'd0);
    check("rst_mid_iready", 64'(i_ready_m), 64'd1);
    check("rst_mid_oresult", 64'(o_result_m), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    hold_rdy = 1'b0;
    repeat (20) tick();
    check("no_stale", 64'(o_valid_m), 64'd0);
    hold_rdy = 1'b1;
    tick();
    fill(8'd1, 8'd1);
    send(0, 0, 0, 1);
    expect_head("post_rst", 32'd64);

    // Saturating vs wrapping accumulate on OPREC=16 instances
    fill(8'd127, 8'd127);
    send(1, 1, 1, 0);
    send(1, 1, 0, 0);
    send(1, 1, 0, 0);
    send(1, 1, 0, 1);
    wait_valid(1'b1);
    check("sat_pos", 64'(o_result_s1), 64'h7FFF);
    check("wrap_pos", 64'(o_result_s0), 64'h0100);
    pop_sat();
    fill(8'h80, 8'd127);
    send(1, 1, 1, 0);
    send(1, 1, 0, 1);
    wait_valid(1'b1);
    check("sat_neg", 64'(o_result_s1), 64'h8000);
    check("wrap_neg", 64'(o_result_s0), 64'h4000);
    pop_sat();
    fill(8'hFF, 8'hFF);
    send(1, 0, 1, 0);
    send(1, 0, 0, 0);
    send(1, 0, 0, 0);
    send(1, 0, 0, 1);
    wait_valid(1'b1);
    check("sat_unsigned", 64'(o_result_s1), 64'h0100);
    check("wrap_unsigned", 64'(o_result_s0), 64'h0100);
    pop_sat();

    check("final_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
